// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory read arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_I,
        OWNER_D
    } arb_owner_t;

    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_INDEX_WIDTH    = 4;
    localparam int DEF_I_INDEX        = 15;
    localparam int DEF_D_INDEX        = 14;
    localparam int DEF_MAX_CONSEC_D   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int TIMER_WIDTH        = 8;

endpackage

// File: rtl/arb_fairness_ctr.sv
// Winner decision between I and D plus the consecutive-D counter that
// stops data reads from starving instruction fetch.
module arb_fairness_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_CONSEC_D = DEF_MAX_CONSEC_D
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic arb_en,
    input  logic i_elig,
    input  logic d_elig,
    output logic grant_i,
    output logic grant_d
);

    localparam int CW = $clog2(MAX_CONSEC_D + 1);

    logic [CW-1:0] consec_d_reg;
    logic          i_priority;

    // I overrides D only once D has had its full run while I was waiting.
    assign i_priority = i_elig && (consec_d_reg == CW'(MAX_CONSEC_D));
    assign grant_i    = arb_en && i_elig && (!d_elig || i_priority);
    assign grant_d    = arb_en && d_elig && !i_priority;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            consec_d_reg <= '0;
        end else if (!i_elig || grant_i) begin
            consec_d_reg <= '0;
        end else if (grant_d) begin
            consec_d_reg <= consec_d_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between instruction fetch (I) and data (D),
// one transaction outstanding, with I flush and a stuck-read timeout.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                     ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int                     DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int                     INDEX_WIDTH    = DEF_INDEX_WIDTH,
    parameter logic [INDEX_WIDTH-1:0] I_INDEX        = INDEX_WIDTH'(DEF_I_INDEX),
    parameter logic [INDEX_WIDTH-1:0] D_INDEX        = INDEX_WIDTH'(DEF_D_INDEX),
    parameter int                     MAX_CONSEC_D   = DEF_MAX_CONSEC_D,
    parameter int                     TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   i_enable_i,
    input  logic [ADDR_WIDTH-1:0]  i_address_i,
    input  logic                   i_flush_i,
    output logic                   i_grant_o,
    output logic                   i_valid_o,
    output logic [DATA_WIDTH-1:0]  i_data_o,
    input  logic                   d_enable_i,
    input  logic [ADDR_WIDTH-1:0]  d_address_i,
    output logic                   d_grant_o,
    output logic                   d_valid_o,
    output logic [DATA_WIDTH-1:0]  d_data_o,
    output logic                   mem_enable_o,
    output logic [ADDR_WIDTH-1:0]  mem_address_o,
    output logic [INDEX_WIDTH-1:0] mem_index_o,
    input  logic                   mem_response_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    output logic                   timeout_o,
    output logic                   timeout_sticky_o
);

    arb_state_t             state_reg, state_next;
    arb_owner_t             owner_reg, owner_next;
    logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
    logic                   drop_reg, drop_next;

    logic                   resp_ok, timeout_hit, arb_en;
    logic                   grant_i, grant_d;
    logic                   i_valid_reg, d_valid_reg;
    logic [DATA_WIDTH-1:0]  i_data_reg, d_data_reg;
    logic                   timeout_reg, sticky_reg;

    assign resp_ok     = (state_reg == WAIT) && mem_response_i;
    assign timeout_hit = (state_reg == WAIT) && !mem_response_i &&
                         (timer_reg == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    // Gating with reset keeps the combinational issue outputs at 0 while held in reset.
    assign arb_en      = reset_n_i && ((state_reg == IDLE) || resp_ok);

    arb_fairness_ctr #(
        .MAX_CONSEC_D (MAX_CONSEC_D)
    ) u_fairness (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .arb_en    (arb_en),
        .i_elig    (i_enable_i && !i_flush_i),
        .d_elig    (d_enable_i),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            owner_reg <= OWNER_NONE;
            timer_reg <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            timer_reg <= timer_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        timer_next = timer_reg;
        drop_next  = drop_reg;
        if (grant_i || grant_d) begin
            state_next = WAIT;
            owner_next = grant_i ? OWNER_I : OWNER_D;
            timer_next = '0;
            drop_next  = 1'b0;
        end else if (resp_ok || timeout_hit) begin
            state_next = IDLE;
            owner_next = OWNER_NONE;
            timer_next = '0;
            drop_next  = 1'b0;
        end else if (state_reg == WAIT) begin
            timer_next = timer_reg + 1'b1;
            if (i_flush_i && (owner_reg == OWNER_I)) begin
                drop_next = 1'b1;
            end
        end
    end

    always_comb begin
        mem_enable_o  = grant_i || grant_d;
        i_grant_o     = grant_i;
        d_grant_o     = grant_d;
        mem_address_o = '0;
        mem_index_o   = '0;
        if (grant_i) begin
            mem_address_o = i_address_i;
            mem_index_o   = I_INDEX;
        end else if (grant_d) begin
            mem_address_o = d_address_i;
            mem_index_o   = D_INDEX;
        end
    end

    // A flushed I response is consumed silently and leaves i_data_o untouched.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            i_valid_reg <= 1'b0;
            d_valid_reg <= 1'b0;
            i_data_reg  <= '0;
            d_data_reg  <= '0;
            timeout_reg <= 1'b0;
            sticky_reg  <= 1'b0;
        end else begin
            i_valid_reg <= resp_ok && (owner_reg == OWNER_I) && !drop_reg && !i_flush_i;
            d_valid_reg <= resp_ok && (owner_reg == OWNER_D);
            if (resp_ok && (owner_reg == OWNER_I) && !drop_reg && !i_flush_i) begin
                i_data_reg <= mem_data_i;
            end
            if (resp_ok && (owner_reg == OWNER_D)) begin
                d_data_reg <= mem_data_i;
            end
            timeout_reg <= timeout_hit;
            if (timeout_hit) begin
                sticky_reg <= 1'b1;
            end
        end
    end

    assign i_valid_o        = i_valid_reg;
    assign d_valid_o        = d_valid_reg;
    assign i_data_o         = i_data_reg;
    assign d_data_o         = d_data_reg;
    assign timeout_o        = timeout_reg;
    assign timeout_sticky_o = sticky_reg;

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one downstream memory read port between two requesters: instruction fetch (port I) and the data/load stage (port D).
- Exactly one transaction is outstanding at a time. Responses are routed back to the requester that issued them.
- An instruction request can be squashed by flush. A stuck read is ended by a timeout.
- Sits between the fetch/memory pipeline stages and the memory-side generic read port.

Parameters:
- ADDR_WIDTH, 16, address width for requesters and memory.
- DATA_WIDTH, 32, read data width.
- INDEX_WIDTH, 4, width of the downstream index field.
- I_INDEX, 15, index value driven for instruction reads.
- D_INDEX, 14, index value driven for data reads.
- MAX_CONSEC_D, 4, maximum consecutive D grants while I is waiting.
- TIMEOUT_CYCLES, 255, number of WAIT cycles without a response before abort; counter is 8 bits.

Ports:
- clock_i  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- i_enable_i  in  1  I read request; held until i_grant_o
- i_address_i  in  ADDR_WIDTH  I read address
- i_flush_i  in  1  drop any outstanding or pending I transaction
- i_grant_o  out  1  1-cycle pulse: I request issued downstream
- i_valid_o  out  1  1-cycle pulse: I data valid
- i_data_o  out  DATA_WIDTH  I read data
- d_enable_i  in  1  D read request; held until d_grant_o
- d_address_i  in  ADDR_WIDTH  D read address
- d_grant_o  out  1  D issue pulse
- d_valid_o  out  1  D data-valid pulse
- d_data_o  out  DATA_WIDTH  D read data
- mem_enable_o  out  1  downstream read strobe (1 cycle per issue)
- mem_address_o  out  ADDR_WIDTH  downstream address
- mem_index_o  out  INDEX_WIDTH  downstream index
- mem_response_i  in  1  downstream response pulse
- mem_data_i  in  DATA_WIDTH  downstream read data
- timeout_o  out  1  1-cycle pulse on abort
- timeout_sticky_o  out  1  latched abort flag, cleared only by reset

Behaviour:
- Reset (async assert, sync deassert at the next clock edge):
  - state IDLE; owner NONE; consec_d and timer 0.
  - All outputs 0, including mem_address_o and i/d_data_o.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; owner register is I or D.
- Arbitration (IDLE, or WAIT in the cycle mem_response_i=1):
  - Eligible I = i_enable_i & !i_flush_i.
  - D wins if eligible, unless I is eligible and consec_d == MAX_CONSEC_D; in that case I wins.
  - A D grant while I is eligible increments consec_d. An I grant, or a cycle with no I waiting, clears consec_d.
- Issue (combinational in the grant cycle):
  - mem_enable_o=1; mem_address_o=winner address; mem_index_o=I_INDEX or D_INDEX.
  - Matching grant pulse asserted.
  - Registered: owner=winner, state=WAIT, timer=0.
- Response in WAIT (mem_response_i=1):
  - Owner's data_o <= mem_data_i and valid_o pulses in the next cycle (1-cycle registered latency).
  - data_o holds its value until the next response to that port.
  - In the same cycle, arbitration may issue back-to-back, staying in WAIT with the new owner; otherwise go to IDLE.
- Responses are accepted only in WAIT. mem_response_i in IDLE is ignored; memory latency is at least 1 cycle after issue.
- Flush:
  - i_flush_i=1 with owner=I in WAIT sets a drop flag.
  - The eventual response is consumed with i_valid_o held 0, then the normal transition follows.
  - Flush in the response cycle also drops.
  - Flush never affects a D transaction.
- Timeout:
  - timer increments each WAIT cycle without a response.
  - At timer == TIMEOUT_CYCLES-1 with no response: timeout_o pulses, timeout_sticky_o sets, no valid is issued, state goes to IDLE.
  - A late response that arrives afterwards is ignored, because it arrives in IDLE.
- Simultaneous I and D requests with consec_d < MAX_CONSEC_D: D wins, I stays pending.
- Reset mid-WAIT: the transaction is abandoned and no valid is produced.

Decomposition:
- Shared package mem_arb_pkg:
  - enum arb_state_t {IDLE, WAIT}
  - enum arb_owner_t {OWNER_NONE, OWNER_I, OWNER_D}
  - default index constants.
- One natural sub-module: arb_fairness_ctr, containing the consec_d counter and the winner decision.

Test Plan:
- I-only read at 0x0100, response 2 cycles after issue with data 0xDEADBEEF → i_grant_o, mem_index_o=15, then i_valid_o with i_data_o=0xDEADBEEF one cycle after the response.
- I and D held continuously, MAX_CONSEC_D=4, memory latency 1 → grant order D,D,D,D,I,D,D,D,D,I; no timeout.
- I issued, i_flush_i pulsed in WAIT, response 0x12345678 → i_valid_o stays 0; next I request is granted normally.
- No response for 255 WAIT cycles → timeout_o pulses once, timeout_sticky_o=1, state IDLE; a response in the following cycle produces no valid.
- Back-to-back: D pending while the I response arrives → d_grant_o in the same cycle as mem_response_i, with mem_index_o=14.
- reset_n_i asserted mid-WAIT → all outputs 0 immediately (async); after release, a stray mem_response_i is ignored.
